// File: rtl/gemm_pkg.sv
// Shared GeMM result-drain types, tile geometry constants and the tile element slicer.
// The element packing index i*NumPE_N+j matches the accelerator's writeback layout.
package gemm_pkg;
  localparam int OutDataWidth  = 32;
  localparam int NumPE_M       = 4;
  localparam int NumPE_N       = 4;
  localparam int OutMemWidth   = 512;
  localparam int AddrWidth     = 16;
  localparam int SizeAddrWidth = 8;

  localparam int TileElems = NumPE_M * NumPE_N;
  localparam int LogM      = $clog2(NumPE_M);
  localparam int LogN      = $clog2(NumPE_N);
  localparam int ElemW     = $clog2(TileElems);
  localparam int MemIdxW   = $clog2(OutMemWidth);
  localparam int TileCntW  = 2 * SizeAddrWidth;

  localparam logic [ElemW-1:0] LastElem = ElemW'(TileElems - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } drain_state_e;

  // With power-of-two NumPE_N, i*NumPE_N+j is just the concatenation {i,j}.
  function automatic logic [OutDataWidth-1:0] tile_elem(input logic [OutMemWidth-1:0] word,
                                                        input logic [LogM-1:0]        i,
                                                        input logic [LogN-1:0]        j);
    logic [MemIdxW-1:0] base;
    base = MemIdxW'({i, j}) * MemIdxW'(OutDataWidth);
    return word[base +: OutDataWidth];
  endfunction
endpackage

// File: rtl/gemm_tile_buffer.sv
// Two-slot FIFO of packed C tiles with a combinational element select on the head slot.
// The caller guarantees push only when a slot is free and pop only when non-empty.
module gemm_tile_buffer
  import gemm_pkg::*;
(
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    push_i,
  input  logic [OutMemWidth-1:0]  push_data_i,
  input  logic                    pop_i,
  input  logic [ElemW-1:0]        elem_idx_i,
  output logic [1:0]              count_o,
  output logic [OutDataWidth-1:0] elem_o
);
  logic [OutMemWidth-1:0] slot_q [2];
  logic                   wr_ptr_q;
  logic                   rd_ptr_q;
  logic [1:0]             count_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      slot_q[0] <= '0;
      slot_q[1] <= '0;
      wr_ptr_q  <= 1'b0;
      rd_ptr_q  <= 1'b0;
      count_q   <= 2'd0;
    end else begin
      if (push_i) begin
        slot_q[wr_ptr_q] <= push_data_i;
        wr_ptr_q         <= ~wr_ptr_q;
      end
      if (pop_i) rd_ptr_q <= ~rd_ptr_q;
      count_q <= count_q + 2'(push_i) - 2'(pop_i);
    end
  end

  assign count_o = count_q;
  assign elem_o  = tile_elem(slot_q[rd_ptr_q], elem_idx_i[ElemW-1:LogN], elem_idx_i[LogN-1:0]);
endmodule

// File: rtl/gemm_result_drain.sv
// Streams packed C tiles from SRAM C as single elements over valid/ready, prefetching 2 tiles.
// Optional GEMM_DRAIN_COORD_EN adds out_row_o/out_col_o global coordinates of each element.
module gemm_result_drain
  import gemm_pkg::*;
(
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     start_i,
  input  logic [SizeAddrWidth-1:0] M_size_i,
  input  logic [SizeAddrWidth-1:0] N_size_i,
  output logic [AddrWidth-1:0]     sram_c_addr_o,
  output logic                     sram_c_re_o,
  input  logic [OutMemWidth-1:0]   sram_c_rdata_i,
  output logic [OutDataWidth-1:0]  out_data_o,
  output logic                     out_valid_o,
  input  logic                     out_ready_i,
  output logic                     out_last_o,
  output logic                     busy_o,
  output logic                     done_o
`ifdef GEMM_DRAIN_COORD_EN
  ,
  output logic [SizeAddrWidth-1:0] out_row_o,
  output logic [SizeAddrWidth-1:0] out_col_o
`endif
);
  // Handshake: a beat moves when out_valid_o && out_ready_i; valid/data/last are
  // registered-only and hold while the consumer stalls.
  drain_state_e             state_q, state_d;
  logic [TileCntW-1:0]      total_q, issued_q, popped_q;
  logic [ElemW-1:0]         elem_q;
  logic                     rvalid_q;
  logic [SizeAddrWidth-1:0] m_tiles_in, n_tiles_in;
  logic [1:0]               count;
  logic [OutDataWidth-1:0]  head_elem;
  logic                     start_take, fire, tile_done, last_beat, issue;

  assign m_tiles_in = M_size_i >> LogM;
  assign n_tiles_in = N_size_i >> LogN;
  assign start_take = (state_q == IDLE) && start_i;

  assign out_valid_o = (state_q == RUN) && (count != 2'd0);
  assign fire        = out_valid_o && out_ready_i;
  assign tile_done   = fire && (elem_q == LastElem);
  assign last_beat   = (elem_q == LastElem) && (popped_q == total_q - TileCntW'(1));

  // A slot freed by this cycle's final-element pop may be refilled immediately.
  assign issue = (state_q == RUN) && (issued_q != total_q) &&
                 (({1'b0, count} + {2'b0, rvalid_q} - {2'b0, tile_done}) < 3'd2);

  assign sram_c_re_o   = issue;
  assign sram_c_addr_o = issue ? issued_q[AddrWidth-1:0] : '0;
  assign out_data_o    = out_valid_o ? head_elem : '0;
  assign out_last_o    = out_valid_o && last_beat;
  assign busy_o        = (state_q == RUN);
  assign done_o        = (state_q == DONE);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (start_i) state_d = ((m_tiles_in == '0) || (n_tiles_in == '0)) ? DONE : RUN;
      RUN:  if (fire && last_beat) state_d = DONE;
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      total_q  <= '0;
      issued_q <= '0;
      popped_q <= '0;
      elem_q   <= '0;
      rvalid_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      rvalid_q <= issue;
      if (start_take) begin
        total_q  <= TileCntW'(m_tiles_in) * TileCntW'(n_tiles_in);
        issued_q <= '0;
        popped_q <= '0;
        elem_q   <= '0;
      end else begin
        if (issue) issued_q <= issued_q + TileCntW'(1);
        if (fire) elem_q <= elem_q + ElemW'(1);
        if (tile_done) popped_q <= popped_q + TileCntW'(1);
      end
    end
  end

  gemm_tile_buffer u_buf (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .push_i      (rvalid_q),
    .push_data_i (sram_c_rdata_i),
    .pop_i       (tile_done),
    .elem_idx_i  (elem_q),
    .count_o     (count),
    .elem_o      (head_elem)
  );

`ifdef GEMM_DRAIN_COORD_EN
  logic [SizeAddrWidth-1:0] n_tiles_q, row_tile_q, col_tile_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      n_tiles_q  <= '0;
      row_tile_q <= '0;
      col_tile_q <= '0;
    end else if (start_take) begin
      n_tiles_q  <= n_tiles_in;
      row_tile_q <= '0;
      col_tile_q <= '0;
    end else if (tile_done) begin
      if (col_tile_q == n_tiles_q - SizeAddrWidth'(1)) begin
        col_tile_q <= '0;
        row_tile_q <= row_tile_q + SizeAddrWidth'(1);
      end else begin
        col_tile_q <= col_tile_q + SizeAddrWidth'(1);
      end
    end
  end

  assign out_row_o = out_valid_o ? SizeAddrWidth'({row_tile_q, elem_q[ElemW-1:LogN]}) : '0;
  assign out_col_o = out_valid_o ? SizeAddrWidth'({col_tile_q, elem_q[LogN-1:0]}) : '0;
`endif
endmodule
